// File: rtl/alu_adder_hold_pkg.sv
// Shared definitions for the 2A03-style ALU adder hold stage: op encoding,
// bus precharge value and the registered result payload.
package alu_adder_hold_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] BUS_PRECHARGE = 8'hFF;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_SUMS = 3'd1,
    OP_ANDS = 3'd2,
    OP_EORS = 3'd3,
    OP_ORS  = 3'd4,
    OP_SRS  = 3'd5
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] add;
    logic              acr;
    logic              avr;
    logic              hc;
  } alu_result_t;

  // Resolve simultaneous strobes: SUMS > ANDS > EORS > ORS > SRS.
  function automatic alu_op_e decode_op(input logic sums, input logic ands,
                                        input logic eors, input logic ors,
                                        input logic srs);
    alu_op_e op;
    if (sums)      op = OP_SUMS;
    else if (ands) op = OP_ANDS;
    else if (eors) op = OP_EORS;
    else if (ors)  op = OP_ORS;
    else if (srs)  op = OP_SRS;
    else           op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/alu_adder_hold_adder8.sv
// Combinational 8-bit binary adder built from two nibbles so the
// half-carry falls out directly; no decimal correction.
module alu_adder8
  import alu_adder_hold_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cin_i,
  output logic [DATA_W-1:0] sum_c,
  output logic              carry_c,
  output logic              half_carry_c,
  output logic              overflow_c
);

  logic [4:0] lo_nib;
  logic [4:0] hi_nib;

  always_comb begin
    lo_nib       = 5'({1'b0, a_i[3:0]}) + 5'({1'b0, b_i[3:0]}) + 5'({4'b0, cin_i});
    hi_nib       = 5'({1'b0, a_i[7:4]}) + 5'({1'b0, b_i[7:4]}) + 5'({4'b0, lo_nib[4]});
    sum_c        = {hi_nib[3:0], lo_nib[3:0]};
    carry_c      = hi_nib[4];
    half_carry_c = lo_nib[4];
    // Signed overflow: operands share a sign that the result does not.
    overflow_c   = ~(a_i[7] ^ b_i[7]) & (a_i[7] ^ sum_c[7]);
  end

endmodule

// File: rtl/alu_adder_hold.sv
// ALU front end: A/B input muxes, op decode and the adder hold register
// with carry, overflow and half-carry flags; one-cycle latency.
module alu_adder_hold
  import alu_adder_hold_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_db,
  input  logic [DATA_W-1:0] i_sb,
  input  logic [DATA_W-1:0] i_adl,
  input  logic              i_0_add,
  input  logic              i_sb_add,
  input  logic              i_db_add,
  input  logic              i_db_n_add,
  input  logic              i_adl_add,
  input  logic              i_sums,
  input  logic              i_ands,
  input  logic              i_eors,
  input  logic              i_ors,
  input  logic              i_srs,
  input  logic              i_addc,
  output logic [DATA_W-1:0] o_add,
  output logic              o_acr,
  output logic              o_avr,
  output logic              o_hc
);

  logic [DATA_W-1:0] ai_c;
  logic [DATA_W-1:0] bi_c;
  alu_op_e           op_c;
  logic [DATA_W-1:0] sum_c;
  logic              carry_c;
  logic              half_carry_c;
  logic              overflow_c;
  alu_result_t       result_d;
  alu_result_t       result_q;

  // Undriven input busses float to the precharged 0xFF.
  always_comb begin
    if (i_0_add)       ai_c = '0;
    else if (i_sb_add) ai_c = i_sb;
    else               ai_c = BUS_PRECHARGE;

    if (i_db_add)        bi_c = i_db;
    else if (i_db_n_add) bi_c = ~i_db;
    else if (i_adl_add)  bi_c = i_adl;
    else                 bi_c = BUS_PRECHARGE;
  end

  assign op_c = decode_op(i_sums, i_ands, i_eors, i_ors, i_srs);

  alu_adder8 u_adder (
    .a_i          (ai_c),
    .b_i          (bi_c),
    .cin_i        (i_addc),
    .sum_c        (sum_c),
    .carry_c      (carry_c),
    .half_carry_c (half_carry_c),
    .overflow_c   (overflow_c)
  );

  always_comb begin
    result_d = result_q;
    case (op_c)
      OP_SUMS: result_d = '{add: sum_c, acr: carry_c, avr: overflow_c, hc: half_carry_c};
      OP_ANDS: result_d = '{add: ai_c & bi_c, acr: 1'b0, avr: 1'b0, hc: 1'b0};
      OP_EORS: result_d = '{add: ai_c ^ bi_c, acr: 1'b0, avr: 1'b0, hc: 1'b0};
      OP_ORS:  result_d = '{add: ai_c | bi_c, acr: 1'b0, avr: 1'b0, hc: 1'b0};
      OP_SRS:  result_d = '{add: {i_addc, ai_c[7:1]}, acr: ai_c[0], avr: 1'b0, hc: 1'b0};
      default: result_d = result_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) result_q <= '0;
    else         result_q <= result_d;
  end

  assign o_add = result_q.add;
  assign o_acr = result_q.acr;
  assign o_avr = result_q.avr;
  assign o_hc  = result_q.hc;

endmodule
